// File: rtl/mul_share_pkg.sv
// Shared definitions for the sequenced 32x32 multiplier: op codes, FSM states,
// partial-product counts and the per-partial shift table.
package mul_share_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULXUU = 2'b01;
    localparam logic [1:0] MUL_OP_MULXSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULXSS = 2'b11;

    localparam int MUL_PARTS_LO = 3;
    localparam int MUL_PARTS_HI = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_RESP
    } mul_seq_state_t;

    function automatic logic [5:0] part_shift(input logic [1:0] k);
        case (k)
            2'd0:    return 6'd0;
            2'd3:    return 6'd32;
            default: return 6'd16;
        endcase
    endfunction

    // Signed operands are handled as unsigned plus a correction of -(other operand) << 32.
    function automatic logic [31:0] sign_corr(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic        a_s;
        logic        b_s;
        logic [31:0] ca;
        logic [31:0] cb;
        a_s = (op == MUL_OP_MULXSU) || (op == MUL_OP_MULXSS);
        b_s = (op == MUL_OP_MULXSS);
        ca  = (a_s && a[31]) ? b : 32'h0;
        cb  = (b_s && b[31]) ? a : 32'h0;
        return ca + cb;
    endfunction

endpackage

// File: rtl/mul_share_seq_cell.sv
// 16x16 unsigned multiplier with a single enabled output register.
module mul16_reg_cell (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [31:0] p_o
);

    logic [31:0] p_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     p_q <= 32'h0;
        else if (en_i) p_q <= 32'(a_i) * 32'(b_i);
    end

    assign p_o = p_q;

endmodule

// File: rtl/mul_share_seq.sv
// Runs a 32x32 multiply as 3 or 4 partial products through one shared 16x16 cell,
// accumulating into 64 bits and returning the low or high word over valid/ready.
module mul_share_seq
    import mul_share_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic        flush_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic        busy_o
);

    mul_seq_state_t state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [63:0] acc_q, acc_d;
    logic [1:0]  k_q, k_d;
    logic [1:0]  pk_q, pk_d;
    logic        pvld_q, pvld_d;
    logic [31:0] resp_data_q, resp_data_d;

    logic        accept;
    logic        cell_en;
    logic [1:0]  last_k;
    logic [15:0] cell_a;
    logic [15:0] cell_b;
    logic [31:0] cell_p;
    logic [63:0] acc_sum;
    logic [31:0] drain_word;

    assign last_k = (op_q == MUL_OP_MUL) ? 2'(MUL_PARTS_LO - 1) : 2'(MUL_PARTS_HI - 1);

    // k[1] picks the a half, k[0] the b half: ll, lh, hl, hh.
    assign cell_a = k_q[1] ? a_q[31:16] : a_q[15:0];
    assign cell_b = k_q[0] ? b_q[31:16] : b_q[15:0];

    mul16_reg_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .en_i  (cell_en),
        .a_i   (cell_a),
        .b_i   (cell_b),
        .p_o   (cell_p)
    );

    assign acc_sum    = acc_q + ({32'h0, cell_p} << part_shift(pk_q));
    assign drain_word = (op_q == MUL_OP_MUL) ? acc_sum[31:0] : acc_sum[63:32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid_i && !flush_i) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (flush_i)              state_d = ST_IDLE;
                else if (k_q == last_k)   state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (flush_i || resp_ready_i) state_d = ST_IDLE;
                else                         state_d = ST_RESP;
            end
            ST_RESP:  if (flush_i || resp_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The final sum is presented combinationally during DRAIN so a ready consumer
    // can take it that cycle; the registered copy holds it through RESP and after.
    always_comb begin
        accept       = (state_q == ST_IDLE) && req_valid_i && !flush_i;
        cell_en      = (state_q == ST_ISSUE) && !flush_i;
        req_ready_o  = (state_q == ST_IDLE);
        busy_o       = (state_q != ST_IDLE);
        resp_valid_o = (state_q == ST_DRAIN) || (state_q == ST_RESP);
        resp_data_o  = (state_q == ST_DRAIN) ? drain_word : resp_data_q;
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        acc_d       = acc_q;
        k_d         = k_q;
        pk_d        = k_q;
        pvld_d      = cell_en;
        resp_data_d = resp_data_q;
        if (accept) begin
            a_d   = req_a_i;
            b_d   = req_b_i;
            op_d  = req_op_i;
            acc_d = {-sign_corr(req_op_i, req_a_i, req_b_i), 32'h0};
            k_d   = 2'd0;
        end else if (pvld_q) begin
            acc_d = acc_sum;
        end
        if (cell_en) k_d = k_q + 2'd1;
        if (state_q == ST_DRAIN && !flush_i) resp_data_d = drain_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            op_q        <= 2'b00;
            acc_q       <= 64'h0;
            k_q         <= 2'd0;
            pk_q        <= 2'd0;
            pvld_q      <= 1'b0;
            resp_data_q <= 32'h0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            pk_q        <= pk_d;
            pvld_q      <= pvld_d;
            resp_data_q <= resp_data_d;
        end
    end

endmodule
